action_selector: RTL

- Reader-side client of the 64x16 action RAM in the Q-learning datapath.
- On a start request for an environment state, it sweeps that state's Q-values out of the RAM through its synchronous read port, finds the greedy action (signed argmax), and applies epsilon-greedy exploration using an internal LFSR.
- It returns the chosen action to the agent controller with a one-cycle done pulse.

---
 rtl/action_selector.sv | 128 ++++++++++++
 1 files changed

// File: rtl/action_selector.sv
// Epsilon-greedy action selector: sweeps one state's Q-values from the action
// RAM, tracks the signed argmax and optionally explores using an LFSR.
module action_selector #(
  parameter int STATE_W = 4,
  parameter int ACT_W   = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  input  logic               explore_en,
  input  logic [7:0]         epsilon,
  output logic               ram_en,
  output logic [ADDR_W-1:0]  ram_rd_addr,
  input  logic [DATA_W-1:0]  ram_data_out,
  output logic               busy,
  output logic               done,
  output logic [ACT_W-1:0]   action,
  output logic [DATA_W-1:0]  q_max,
  output logic               explored
);

  typedef enum logic [2:0] {
    IDLE, READ, DRAIN, DECIDE, DONE
  } fsm_t;

  fsm_t fsm, fsm_nxt;

  logic [STATE_W-1:0]       state_q;
  logic [ACT_W-1:0]         act_cnt;
  logic [ACT_W-1:0]         idx_q;
  logic [ACT_W-1:0]         best_idx;
  logic signed [DATA_W-1:0] best_q;
  logic                     valid_q;
  logic                     first_q;
  logic [15:0]              lfsr;
  logic                     fb;
  logic                     last;
  logic                     explore;

  assign last    = &act_cnt;
  assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign explore = explore_en && (lfsr[7:0] < epsilon);

  assign ram_rd_addr = {state_q, act_cnt};

  always_comb begin
    fsm_nxt = fsm;
    ram_en  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (fsm)
      IDLE: begin
        if (start) fsm_nxt = READ;
      end
      READ: begin
        ram_en = 1'b1;
        busy   = 1'b1;
        if (last) fsm_nxt = DRAIN;
      end
      DRAIN: begin
        ram_en  = 1'b1;
        busy    = 1'b1;
        fsm_nxt = DECIDE;
      end
      DECIDE: begin
        busy    = 1'b1;
        fsm_nxt = DONE;
      end
      DONE: begin
        done    = 1'b1;
        fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= IDLE;
      state_q  <= '0;
      act_cnt  <= '0;
      idx_q    <= '0;
      best_idx <= '0;
      best_q   <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      lfsr     <= 16'hACE1;
      action   <= '0;
      q_max    <= '0;
      explored <= 1'b0;
    end else begin
      fsm     <= fsm_nxt;
      lfsr    <= {lfsr[14:0], fb};
      // RAM data lags the address by one cycle
      valid_q <= (fsm == READ);
      first_q <= (fsm == READ) && (act_cnt == '0);
      idx_q   <= act_cnt;
      if (fsm == IDLE && start) begin
        state_q  <= state_in;
        act_cnt  <= '0;
        best_q   <= '0;
        best_idx <= '0;
      end
      if (fsm == READ && !last) begin
        act_cnt <= act_cnt + 1'b1;
      end
      if (valid_q &&
          (first_q || $signed(ram_data_out) > best_q)) begin
        best_q   <= $signed(ram_data_out);
        best_idx <= idx_q;
      end
      if (fsm == DECIDE) begin
        q_max <= best_q;
        if (explore) begin
          action   <= lfsr[ACT_W+7:8];
          explored <= 1'b1;
        end else begin
          action   <= best_idx;
          explored <= 1'b0;
        end
      end
    end
  end

endmodule
